tc_bank: RTL and testbench

Parametrised multi-channel timer/counter block, successor to the single two-instance timer arrangement in the MIPS top. It holds NUM_CH independent down-counters behind one word-addressed register window on the bridge side. Each channel has a prescaler, one-shot/periodic modes and a sticky, write-1-to-clear pending flag. It produces a per-channel irq vector plus an OR-reduced irq for the HWInt bus.

---
 rtl/tc_pkg.sv | 37 +++
 rtl/tc_channel.sv | 104 ++++++++++
 rtl/tc_bank.sv | 69 ++++++
 tb/tb_tc_bank.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared types for the tc_bank timer/counter block.
// State encoding, register offsets, CTRL field layout, MODE codes.
package tc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } tc_state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;
  localparam int CTRL_DIV  = 4;

  // 2'b1x is reserved and behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  typedef struct packed {
    logic [3:0] div;
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  function automatic int ch_bits(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tc_channel.sv
// One timer channel: CTRL/PRESET/COUNT/pending, prescaler, FSM.
// Ports: clk, reset (sync, low), per-register write strobes, wdata, register views, irq.
module tc_channel
  import tc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_ctrl,
  input  logic             we_preset,
  input  logic             we_status,
  input  logic [WIDTH-1:0] wdata,
  output logic [7:0]       ctrl,
  output logic [WIDTH-1:0] preset,
  output logic [WIDTH-1:0] count,
  output logic             pending,
  output logic             irq
);

  tc_state_e        state;
  ctrl_t            ctrl_q;
  ctrl_t            ctrl_nxt;
  logic [WIDTH-1:0] preset_q;
  logic [WIDTH-1:0] count_q;
  logic             pend_q;
  logic [15:0]      presc;
  logic [15:0]      presc_max;
  logic             tick;

  // The FSM looks at the post-write CTRL so EN takes effect at the
  // same edge the CPU writes it.
  always_comb begin
    ctrl_nxt = ctrl_q;
    if (we_ctrl) begin
      ctrl_nxt.en   = wdata[CTRL_EN];
      ctrl_nxt.mode = wdata[CTRL_MODE +: 2];
      ctrl_nxt.im   = wdata[CTRL_IM];
      ctrl_nxt.div  = wdata[CTRL_DIV +: 4];
    end
  end

  assign presc_max = (16'd1 << ctrl_q.div) - 16'd1;
  assign tick      = (state == CNT) && (presc == presc_max);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ctrl_q   <= '{div: 4'd0, im: 1'b0, mode: MODE_ONESHOT, en: 1'b0};
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      presc    <= '0;
    end else begin
      ctrl_q <= ctrl_nxt;
      if (we_preset) preset_q <= wdata;
      // hardware set below overrides this clear
      if (we_status && wdata[0]) pend_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ctrl_nxt.en) state <= LOAD;
        end
        LOAD: begin
          count_q <= preset_q;
          presc   <= '0;
          state   <= CNT;
        end
        CNT: begin
          if (!ctrl_nxt.en) begin
            state <= IDLE;
          end else if (tick) begin
            presc <= '0;
            if (count_q > WIDTH'(1)) begin
              count_q <= count_q - WIDTH'(1);
            end else begin
              count_q <= '0;
              pend_q  <= 1'b1;
              state   <= INT;
            end
          end else begin
            presc <= presc + 16'd1;
          end
        end
        INT: begin
          if (ctrl_q.mode == MODE_PERIODIC) begin
            state <= LOAD;
          end else begin
            state <= IDLE;
            // a CPU CTRL write in this cycle wins
            if (!we_ctrl) ctrl_q.en <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ctrl    = ctrl_q;
  assign preset  = preset_q;
  assign count   = count_q;
  assign pending = pend_q;
  assign irq     = pend_q & ctrl_q.im;

endmodule

// File: rtl/tc_bank.sv
// Multi-channel timer/counter bank behind a word-addressed window.
// Ports: clk, reset (sync, low), addr/we/wdata/rdata bus, irq vector, irq_any.
module tc_bank
  import tc_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int WIDTH   = 32,
  localparam int CH_BITS = ch_bits(NUM_CH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CH_BITS+1:0] addr,
  input  logic               we,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic [NUM_CH-1:0]  irq,
  output logic               irq_any
);

  logic [CH_BITS-1:0] ch;
  logic [1:0]         rsel;
  logic               in_range;

  logic [7:0]       ctrl_v   [NUM_CH];
  logic [WIDTH-1:0] preset_v [NUM_CH];
  logic [WIDTH-1:0] count_v  [NUM_CH];
  logic [NUM_CH-1:0] pend_v;

  assign ch       = addr[CH_BITS+1:2];
  assign rsel     = addr[1:0];
  assign in_range = (32'(ch) < 32'(NUM_CH));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = we && in_range && (ch == CH_BITS'(i));

    tc_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .we_ctrl   (sel && (rsel == REG_CTRL)),
      .we_preset (sel && (rsel == REG_PRESET)),
      .we_status (sel && (rsel == REG_STATUS)),
      .wdata     (wdata[WIDTH-1:0]),
      .ctrl      (ctrl_v[i]),
      .preset    (preset_v[i]),
      .count     (count_v[i]),
      .pending   (pend_v[i]),
      .irq       (irq[i])
    );
  end

  always_comb begin
    rdata = '0;
    if (in_range) begin
      unique case (rsel)
        REG_CTRL:   rdata = {24'd0, ctrl_v[ch]};
        REG_PRESET: rdata = 32'(preset_v[ch]);
        REG_COUNT:  rdata = 32'(count_v[ch]);
        REG_STATUS: rdata = {31'd0, pend_v[ch]};
        default:    rdata = '0;
      endcase
    end
  end

  assign irq_any = |irq;

endmodule

// File: tb/tb_tc_bank.sv
// Self-checking bench for tc_bank: a 4-channel 32-bit bank
// and a 3-channel 8-bit bank for range and width corners.
module tb_tc_bank;

  logic        clk = 1'b0;
  logic        reset;

  logic [3:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  irq;
  logic        irq_any;

  logic [3:0]  s_addr;
  logic        s_we;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic [2:0]  s_irq;
  logic        s_irq_any;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sbq[$];

  always #10 clk = ~clk;

  tc_bank #(.NUM_CH(4), .WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .irq(irq), .irq_any(irq_any)
  );

  tc_bank #(.NUM_CH(3), .WIDTH(8)) u_small (
    .clk(clk), .reset(reset), .addr(s_addr), .we(s_we),
    .wdata(s_wdata), .rdata(s_rdata), .irq(s_irq),
    .irq_any(s_irq_any)
  );

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h",
                  tag, got, exp);
  endtask

  function automatic logic [3:0] ra(int c, int r);
    return 4'(c * 4 + r);
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(int c, int r, logic [31:0] d);
    addr  = ra(c, r);
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic s_wr(int c, int r, logic [31:0] d);
    s_addr  = ra(c, r);
    s_wdata = d;
    s_we    = 1'b1;
    @(negedge clk);
    s_we    = 1'b0;
  endtask

  task automatic rd(string tag, int c, int r, logic [31:0] v);
    exp_t e;
    sbq.push_back('{tag: tag, v: v});
    addr = ra(c, r);
    #1;
    e = sbq.pop_front();
    check(e.tag, rdata, e.v);
  endtask

  task automatic s_rd(string tag, int c, int r, logic [31:0] v);
    exp_t e;
    sbq.push_back('{tag: tag, v: v});
    s_addr = ra(c, r);
    #1;
    e = sbq.pop_front();
    check(e.tag, s_rdata, e.v);
  endtask

  initial begin
    reset   = 1'b0;
    addr    = '0;
    we      = 1'b0;
    wdata   = '0;
    s_addr  = '0;
    s_we    = 1'b0;
    s_wdata = '0;
    cyc();
    cyc();
    reset = 1'b1;

    // reset state
    for (int r = 0; r < 4; r++) begin
      rd("rst_ch0", 0, r, 32'h0);
      rd("rst_ch3", 3, r, 32'h0);
    end
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_any", 32'(irq_any), 32'h0);

    // ch0 one-shot, P=3
    wr(0, 1, 32'd3);
    wr(0, 0, 32'h9);
    rd("c0_load", 0, 2, 32'd0);
    cyc(); rd("c0_cnt3", 0, 2, 32'd3);
    cyc(); rd("c0_cnt2", 0, 2, 32'd2);
    cyc(); rd("c0_cnt1", 0, 2, 32'd1);
    check("c0_irq_pre", 32'(irq), 32'h0);
    cyc(); rd("c0_cnt0", 0, 2, 32'd0);
    check("c0_irq_set", 32'(irq), 32'h1);
    rd("c0_ctrl_int", 0, 0, 32'h9);
    cyc(); rd("c0_ctrl_off", 0, 0, 32'h8);
    check("c0_irq_hold", 32'(irq), 32'h1);
    wr(0, 3, 32'h1);
    check("c0_irq_clr", 32'(irq), 32'h0);
    rd("c0_stat_clr", 0, 3, 32'h0);

    // ch1 periodic, P=2, period 4
    wr(1, 1, 32'd2);
    wr(1, 0, 32'hB);
    cyc(); cyc();
    check("c1_any_pre", 32'(irq_any), 32'h0);
    cyc();
    check("c1_irq_a", 32'(irq), 32'h2);
    check("c1_any_a", 32'(irq_any), 32'h1);
    wr(1, 3, 32'h1);
    check("c1_irq_clr", 32'(irq), 32'h0);
    cyc(); cyc();
    check("c1_irq_gap", 32'(irq), 32'h0);
    cyc();
    check("c1_irq_b", 32'(irq), 32'h2);
    check("c1_any_b", 32'(irq_any), 32'h1);
    wr(1, 3, 32'h1);
    wr(1, 0, 32'h0);
    cyc(); cyc();
    check("c1_irq_off", 32'(irq), 32'h0);
    check("c1_any_off", 32'(irq_any), 32'h0);
    rd("c1_cnt_hold", 1, 2, 32'd2);

    // ch2 DIV=2, count moves every 4th CNT cycle
    wr(2, 1, 32'd5);
    wr(2, 0, 32'h21);
    cyc(); rd("c2_e1", 2, 2, 32'd5);
    cyc(); cyc(); cyc();
    rd("c2_e4", 2, 2, 32'd5);
    cyc(); rd("c2_e5", 2, 2, 32'd4);
    wr(2, 2, 32'h77);
    rd("c2_cnt_ro", 2, 2, 32'd4);
    cyc(); cyc();
    rd("c2_e8", 2, 2, 32'd4);
    cyc(); rd("c2_e9", 2, 2, 32'd3);
    wr(2, 0, 32'h20);
    rd("c2_stop", 2, 2, 32'd3);
    for (int i = 0; i < 4; i++) cyc();
    rd("c2_held", 2, 2, 32'd3);
    rd("c2_ctrl", 2, 0, 32'h20);
    check("c2_no_irq", 32'(irq), 32'h0);

    // ch3: W1C in the same cycle as the hardware set
    wr(3, 1, 32'd2);
    wr(3, 0, 32'h9);
    cyc(); cyc();
    rd("c3_stat_pre", 3, 3, 32'h0);
    wr(3, 3, 32'h1);
    rd("c3_set_wins", 3, 3, 32'h1);
    check("c3_irq", 32'(irq), 32'h8);
    cyc(); rd("c3_ctrl", 3, 0, 32'h8);
    wr(3, 3, 32'h1);
    rd("c3_stat_clr", 3, 3, 32'h0);
    check("c3_irq_clr", 32'(irq), 32'h0);

    // 3-channel, 8-bit bank: out-of-range index and truncation
    s_wr(3, 0, 32'h9);
    s_wr(3, 1, 32'h55);
    for (int r = 0; r < 4; r++) s_rd("s_oor", 3, r, 32'h0);
    s_rd("s_c2_ctrl", 2, 0, 32'h0);
    s_rd("s_c0_ctrl", 0, 0, 32'h0);
    check("s_irq_idle", 32'(s_irq), 32'h0);
    s_wr(0, 1, 32'h1FF);
    s_rd("s_preset_w", 0, 1, 32'hFF);
    s_wr(0, 0, 32'h9);
    cyc(); s_rd("s_cnt_ff", 0, 2, 32'hFF);
    cyc(); s_rd("s_cnt_fe", 0, 2, 32'hFE);

    // reset mid-count
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    s_rd("s_rst_cnt", 0, 2, 32'h0);
    s_rd("s_rst_ctrl", 0, 0, 32'h0);
    s_rd("s_rst_pre", 0, 1, 32'h0);
    check("s_rst_irq", 32'(s_irq), 32'h0);
    rd("rst_c2_cnt", 2, 2, 32'h0);
    for (int i = 0; i < 300; i++) begin
      if (s_irq_any !== 1'b0) break;
      cyc();
    end
    check("s_no_irq", 32'(s_irq_any), 32'h0);
    check("sb_empty", 32'(sbq.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
